// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin arbiter granting one of two requesters a DRAM port group
// Drives the captured request until every enabled lane has returned or the timeout expires.
module dram_arbiter #(
  parameter int LANES   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [2*LANES-1:0]    req_en,
  input  logic [1:0]            req_rdwr,
  input  logic [2*LANES*64-1:0] req_addr,
  input  logic [2*LANES*8-1:0]  req_wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            done,
  output logic [1:0]            err,
  output logic [2*LANES-1:0]    rvalid,
  output logic [2*LANES*8-1:0]  rdata,
  output logic [LANES-1:0]      dram_en,
  output logic                  dram_rdwr,
  output logic [LANES*64-1:0]   dram_addr,
  output logic [LANES*8-1:0]    dram_wdata,
  input  logic [LANES*8-1:0]    dram_data,
  input  logic [LANES-1:0]      dram_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic                owner;
  logic                last_grant;
  logic [LANES-1:0]    en_q;
  logic                rdwr_q;
  logic [LANES*64-1:0] addr_q;
  logic [LANES*8-1:0]  wdata_q;
  logic [LANES-1:0]    seen;
  logic [CW-1:0]       cnt;

  logic             sel;
  logic             busy;
  logic             complete;
  logic [LANES-1:0] hit;
  logic [1:0]       owner_oh;

  // On a tie the requester that did not win last time goes first.
  assign sel      = (req == 2'b11) ? ~last_grant : req[1];
  assign busy     = (state == BUSY);
  assign hit      = dram_valid & en_q;
  assign complete = ((seen | hit) == en_q);
  assign owner_oh = owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      en_q       <= '0;
      rdwr_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      seen       <= '0;
      cnt        <= '0;
      gnt        <= 2'b00;
      done       <= 2'b00;
      err        <= 2'b00;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      err  <= 2'b00;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= BUSY;
            owner      <= sel;
            last_grant <= sel;
            en_q       <= sel ? req_en[LANES +: LANES] : req_en[0 +: LANES];
            rdwr_q     <= req_rdwr[sel];
            addr_q     <= sel ? req_addr[LANES*64 +: LANES*64] : req_addr[0 +: LANES*64];
            wdata_q    <= sel ? req_wdata[LANES*8 +: LANES*8] : req_wdata[0 +: LANES*8];
            seen       <= '0;
            cnt        <= '0;
            gnt        <= sel ? 2'b10 : 2'b01;
          end
        end
        BUSY: begin
          seen <= seen | hit;
          cnt  <= cnt + CW'(1);
          // A lane set finishing on the last allowed cycle is still a success.
          if (complete) begin
            state <= DONE;
            done  <= owner_oh;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            done  <= owner_oh;
            err   <= owner_oh;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dram_en    = '0;
    dram_rdwr  = 1'b0;
    dram_addr  = '0;
    dram_wdata = '0;
    rvalid     = '0;
    rdata      = '0;
    if (busy) begin
      dram_en    = en_q;
      dram_rdwr  = rdwr_q;
      dram_addr  = addr_q;
      dram_wdata = wdata_q;
      if (owner) begin
        rvalid[LANES +: LANES]     = hit;
        rdata[LANES*8 +: LANES*8]  = dram_data;
      end else begin
        rvalid[0 +: LANES]         = hit;
        rdata[0 +: LANES*8]        = dram_data;
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter
// Vector table, directed corner sequences and randomized transactions against a transaction-level model.
module tb_dram_arbiter;
  localparam int LANES   = 8;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [15:0]   req_en;
  logic [1:0]    req_rdwr;
  logic [1023:0] req_addr;
  logic [127:0]  req_wdata;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [15:0]   rvalid;
  logic [127:0]  rdata;
  logic [7:0]    dram_en;
  logic          dram_rdwr;
  logic [511:0]  dram_addr;
  logic [63:0]   dram_wdata;
  logic [63:0]   dram_data;
  logic [7:0]    dram_valid;

  always #5 clk = ~clk;

  dram_arbiter #(.LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_en(req_en), .req_rdwr(req_rdwr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rvalid(rvalid), .rdata(rdata), .dram_en(dram_en), .dram_rdwr(dram_rdwr),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_data(dram_data),
    .dram_valid(dram_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model_last = 1;

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  en0;
    logic [7:0]  en1;
    logic [1:0]  rdwr;
    logic [7:0]  valid;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [7:0]  dram_en;
    logic        dram_rdwr;
    logic [15:0] rvalid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] place_v(input int own, input logic [7:0] x);
    return (own == 1) ? {x, 8'h00} : {8'h00, x};
  endfunction

  function automatic logic [127:0] place_d(input int own, input logic [63:0] x);
    return (own == 1) ? {x, 64'h0} : {64'h0, x};
  endfunction

  task automatic scramble();
    req_en   = 16'($urandom);
    req_rdwr = 2'($urandom);
    for (int i = 0; i < 16; i++) req_addr[i*64 +: 64] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) req_wdata[i*32 +: 32] = $urandom;
  endtask

  // One transaction: owner chosen by the arbitration rule, length set by lane coverage or timeout.
  task automatic rand_txn(input int t);
    logic [1:0]   r;
    logic [1:0]   oh;
    int           own;
    int           k;
    logic [7:0]   en_s;
    logic [7:0]   seen;
    logic [7:0]   v;
    logic         rw;
    logic [511:0] addr_s;
    logic [63:0]  wd_s;
    logic [63:0]  dd;
    bit           sparse;
    bit           fin;
    bit           to;
    r   = 2'(1 + $urandom_range(2));
    own = (r == 2'b11) ? 1 - model_last : ((r == 2'b10) ? 1 : 0);
    model_last = own;
    oh  = (own == 1) ? 2'b10 : 2'b01;
    sparse = ($urandom_range(1) == 1);
    tick();
    scramble();
    if ($urandom_range(7) == 0) req_en[own*LANES +: LANES] = 8'h00;
    req        = r;
    dram_valid = 8'h00;
    en_s   = req_en[own*LANES +: LANES];
    rw     = req_rdwr[own];
    addr_s = req_addr[own*512 +: 512];
    wd_s   = req_wdata[own*64 +: 64];
    #1;
    chk($sformatf("rnd%0d_idle_gnt", t), 512'(gnt), 512'(2'b00));
    chk($sformatf("rnd%0d_idle_en", t), 512'(dram_en), 512'(8'h00));
    seen = 8'h00;
    fin  = 1'b0;
    to   = 1'b0;
    k    = 0;
    while (!fin) begin
      tick();
      req = 2'b00;
      scramble();
      v  = sparse ? 8'($urandom & $urandom & $urandom) : 8'($urandom);
      dd = {$urandom, $urandom};
      dram_valid = v;
      dram_data  = dd;
      #1;
      chk($sformatf("rnd%0d_b%0d_gnt", t, k), 512'(gnt), 512'((k == 0) ? oh : 2'b00));
      chk($sformatf("rnd%0d_b%0d_en", t, k), 512'(dram_en), 512'(en_s));
      chk($sformatf("rnd%0d_b%0d_rdwr", t, k), 512'(dram_rdwr), 512'(rw));
      chk($sformatf("rnd%0d_b%0d_addr", t, k), dram_addr, addr_s);
      chk($sformatf("rnd%0d_b%0d_wdata", t, k), 512'(dram_wdata), 512'(wd_s));
      chk($sformatf("rnd%0d_b%0d_rvalid", t, k), 512'(rvalid), 512'(place_v(own, v & en_s)));
      chk($sformatf("rnd%0d_b%0d_rdata", t, k), 512'(rdata), 512'(place_d(own, dd)));
      seen = seen | (v & en_s);
      if (seen == en_s) fin = 1'b1;
      else if (k == TIMEOUT - 1) begin
        fin = 1'b1;
        to  = 1'b1;
      end
      k++;
    end
    tick();
    dram_valid = 8'h00;
    #1;
    chk($sformatf("rnd%0d_done", t), 512'(done), 512'(oh));
    chk($sformatf("rnd%0d_err", t), 512'(err), 512'(to ? oh : 2'b00));
    chk($sformatf("rnd%0d_done_en", t), 512'(dram_en), 512'(8'h00));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] grants[$];
    int         gcyc[$];
    int         nb;
    bit         got;

    // req, en0, en1, rdwr, valid | gnt, done, err, dram_en, dram_rdwr, rvalid
    vecs.push_back('{2'b01, 8'hFF, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b01, 2'b00, 2'b00, 8'hFF, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'hFF, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'hFF, 2'b00, 2'b00, 2'b00, 8'hFF, 1'b0, 16'h00FF});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b10, 8'hA5, 8'h00, 2'b10, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'hFF, 2'b00, 8'hFF, 2'b10, 2'b00, 2'b00, 8'h00, 1'b1, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b10, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b01, 8'h0F, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'hF0, 2'b01, 2'b00, 2'b00, 8'h0F, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h03, 2'b00, 2'b00, 2'b00, 8'h0F, 1'b0, 16'h0003});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h0C, 2'b00, 2'b00, 2'b00, 8'h0F, 1'b0, 16'h000C});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b01, 2'b00, 8'h00, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 16'h0000});

    rst_n      = 1'b0;
    req        = 2'b11;
    req_en     = 16'hFFFF;
    req_rdwr   = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    dram_data  = 64'hDEAD_BEEF_0BAD_F00D;
    dram_valid = 8'hFF;
    repeat (3) tick();
    #1;
    chk("rst_gnt", 512'(gnt), 512'(2'b00));
    chk("rst_done", 512'(done), 512'(2'b00));
    chk("rst_err", 512'(err), 512'(2'b00));
    chk("rst_dram_en", 512'(dram_en), 512'(8'h00));
    chk("rst_rvalid", 512'(rvalid), 512'(16'h0000));
    chk("rst_rdata", 512'(rdata), 512'(128'h0));
    chk("rst_addr", dram_addr, 512'h0);

    // Both requesters held: grants alternate starting with 0, three cycles apart.
    tick();
    rst_n = 1'b1;
    #1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      #1;
      if (gnt != 2'b00) begin
        grants.push_back(gnt);
        gcyc.push_back(c);
      end
      if (grants.size() == 4) break;
    end
    chk("rr_count", 512'(grants.size()), 512'(4));
    for (int i = 0; i < grants.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 512'(grants[i]), 512'((i % 2 == 0) ? 2'b01 : 2'b10));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 512'(gcyc[i] - gcyc[i-1]), 512'(3));
    end
    tick();
    req        = 2'b00;
    dram_valid = 8'h00;
    dram_data  = 64'h0;
    #1;
    chk("rr_last_done", 512'(done), 512'(2'b10));

    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      req        = vecs[i].req;
      req_en     = {vecs[i].en1, vecs[i].en0};
      req_rdwr   = vecs[i].rdwr;
      dram_valid = vecs[i].valid;
      #1;
      chk($sformatf("row%0d_gnt", i), 512'(gnt), 512'(vecs[i].gnt));
      chk($sformatf("row%0d_done", i), 512'(done), 512'(vecs[i].done));
      chk($sformatf("row%0d_err", i), 512'(err), 512'(vecs[i].err));
      chk($sformatf("row%0d_dram_en", i), 512'(dram_en), 512'(vecs[i].dram_en));
      chk($sformatf("row%0d_dram_rdwr", i), 512'(dram_rdwr), 512'(vecs[i].dram_rdwr));
      chk($sformatf("row%0d_rvalid", i), 512'(rvalid), 512'(vecs[i].rvalid));
    end

    // DRAM never answers: timeout after TIMEOUT busy cycles.
    tick();
    req        = 2'b01;
    req_en     = 16'h00FF;
    req_rdwr   = 2'b00;
    dram_valid = 8'h00;
    #1;
    nb  = 0;
    got = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      req = 2'b00;
      #1;
      if (dram_en != 8'h00) nb++;
      if (done != 2'b00) begin
        chk("to_done", 512'(done), 512'(2'b01));
        chk("to_err", 512'(err), 512'(2'b01));
        got = 1'b1;
        break;
      end
    end
    chk("to_seen_done", 512'(got), 512'(1'b1));
    chk("to_busy_cycles", 512'(nb), 512'(TIMEOUT));

    tick();
    req    = 2'b01;
    req_en = 16'h00FF;
    #1;
    chk("to_idle_en", 512'(dram_en), 512'(8'h00));
    chk("to_idle_done", 512'(done), 512'(2'b00));
    // Completion on the final allowed cycle is a success.
    for (int k = 0; k < TIMEOUT; k++) begin
      tick();
      req        = 2'b00;
      dram_valid = (k == TIMEOUT - 1) ? 8'hFF : 8'h00;
      #1;
      if (k == 0) chk("edge_gnt", 512'(gnt), 512'(2'b01));
      chk($sformatf("edge_b%0d_en", k), 512'(dram_en), 512'(8'hFF));
    end
    tick();
    dram_valid = 8'h00;
    #1;
    chk("edge_done", 512'(done), 512'(2'b01));
    chk("edge_err", 512'(err), 512'(2'b00));

    // Reset in the second busy cycle drops the transaction.
    tick();
    req    = 2'b01;
    req_en = 16'hFFFF;
    #1;
    tick();
    req = 2'b00;
    #1;
    chk("rmid_gnt", 512'(gnt), 512'(2'b01));
    tick();
    rst_n = 1'b0;
    req   = 2'b10;
    #1;
    chk("rmid_busy_en", 512'(dram_en), 512'(8'hFF));
    tick();
    rst_n      = 1'b1;
    dram_valid = 8'hFF;
    dram_data  = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("rmid_gnt0", 512'(gnt), 512'(2'b00));
    chk("rmid_done0", 512'(done), 512'(2'b00));
    chk("rmid_err0", 512'(err), 512'(2'b00));
    chk("rmid_en0", 512'(dram_en), 512'(8'h00));
    chk("rmid_rvalid0", 512'(rvalid), 512'(16'h0000));
    chk("rmid_rdata0", 512'(rdata), 512'(128'h0));
    tick();
    #1;
    chk("rmid_next_gnt", 512'(gnt), 512'(2'b10));
    chk("rmid_next_done", 512'(done), 512'(2'b00));
    req = 2'b00;
    tick();
    #1;
    chk("rmid_req1_done", 512'(done), 512'(2'b10));

    model_last = 1;
    for (int t = 0; t < 60; t++) rand_txn(t);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter LANES, default 8, meaning byte lanes per DRAM port group.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning max BUSY cycles before forced release.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port req  input  2  per-requester transaction request (bit 0 fetch, bit 1 second client).
REQ-006 SHALL have port req_en  input  2 x LANES  per-requester lane enables.
REQ-007 SHALL have port req_rdwr  input  2  per-requester direction, 0 = read, 1 = write.
REQ-008 SHALL have port req_addr  input  2 x LANES x 64  per-requester per-lane byte address.
REQ-009 SHALL have port req_wdata  input  2 x LANES x 8  per-requester per-lane write byte.
REQ-010 SHALL have port gnt  output  2  one-cycle grant pulse.
REQ-011 SHALL have port done  output  2  one-cycle completion pulse.
REQ-012 SHALL have port err  output  2  one-cycle timeout flag, coincident with done.
REQ-013 SHALL have port rvalid  output  2 x LANES  per-requester lane-valid return.
REQ-014 SHALL have port rdata  output  2 x LANES x 8  per-requester read bytes.
REQ-015 SHALL have ports dram_en (output, LANES), dram_rdwr (output, 1), dram_addr (output, LANES x 64), dram_wdata (output, LANES x 8): DRAM port-group drive.
REQ-016 SHALL have ports dram_data (input, LANES x 8) and dram_valid (input, LANES): DRAM return.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-018 In IDLE with exactly one req bit high, SHALL select that requester; with both high, SHALL select requester != last_grant (round-robin).
REQ-019 On the IDLE->BUSY edge, SHALL capture selected en/rdwr/addr/wdata into registers, set owner = selected, set last_grant = selected, clear seen mask and timeout counter.
REQ-020 gnt[owner] SHALL be 1 for exactly the first BUSY cycle (registered, one cycle after req sampled).
REQ-021 During BUSY, dram_en SHALL equal the latched enable and the dram_rdwr/addr/wdata outputs SHALL equal the latched values; in IDLE and DONE, dram_en SHALL be 0.
REQ-022 During BUSY, rvalid[owner] SHALL be dram_valid AND latched enable, and rdata[owner] SHALL be dram_data; non-owner rvalid/rdata, and both outside BUSY, SHALL be 0.
REQ-023 seen SHALL accumulate dram_valid AND latched enable each BUSY cycle; dram_valid on non-enabled lanes SHALL be ignored.
REQ-024 Completion = (seen OR (dram_valid AND en)) == en; when true in BUSY, next state SHALL be DONE.
REQ-025 A latched enable of all-zero SHALL complete in the first BUSY cycle (DONE on the next cycle).
REQ-026 The timeout counter SHALL increment each BUSY cycle; on reaching TIMEOUT-1 without completion, next state SHALL be DONE with err[owner] set.
REQ-027 In DONE, done[owner] SHALL be 1 for one cycle and err[owner] SHALL be 1 only if timed out; completion on the same cycle as the timeout SHALL count as success (err 0).
REQ-028 Deassertion of req during BUSY SHALL NOT abort the transaction; input changes after capture SHALL be ignored.
REQ-029 A req still high in the DONE cycle SHALL be arbitrated anew in the following IDLE cycle (minimum 3-cycle turnaround).

Reset
REQ-030 While reset = 0 at a clock edge: state SHALL be IDLE; last_grant SHALL be 1 (requester 0 wins the first tie); seen and counter SHALL be 0; all outputs SHALL be 0 on the next cycle, including mid-BUSY (transaction dropped, no done).

Verification
REQ-031 req=01, en0=FF, rd, DRAM returns all lanes 2 cycles later -> gnt0 pulse, dram_en=FF for 3 cycles, rvalid0=FF, done0 pulse, err=00.
REQ-032 req=11 held continuously, both en=FF -> grants alternate 0,1,0,1; the first grant after reset goes to 0.
REQ-033 en0=0F with dram_valid 03 then 0C on successive cycles -> done0 after second beat; dram_valid F0 ignored.
REQ-034 TIMEOUT=8, dram_valid never asserted -> done0 and err0 after 8 BUSY cycles, FSM returns to IDLE.
REQ-035 reset=0 in the second BUSY cycle -> next cycle all outputs 0, no done; req1 next wins arbitration.
REQ-036 en1=00 write -> gnt1, one BUSY cycle with dram_en=00, done1 the next cycle.
